// File: rtl/otp_sched_if.sv
// Bundles the otp_sched control, pad-generator and block-RAM signals.
// The slave modport is the scheduler side; master is the SD FSM / OTP / RAM side.
interface otp_sched_if #(
  parameter int ADDR_W = 10,
  parameter int PAD_W  = 64
);
  logic              istart;
  logic              inew;
  logic              ogen_otp;
  logic              onew_otp;
  logic              iotp_ready;
  logic [PAD_W-1:0]  ipad;
  logic [ADDR_W-1:0] oaddr_rd;
  logic [3:0]        irdata;
  logic [ADDR_W-1:0] oaddr_wr;
  logic [3:0]        owdata;
  logic              owrite_en;
  logic              obusy;
  logic              odone;
  logic              otimeout;

  modport slave (
    input  istart, inew, iotp_ready, ipad, irdata,
    output ogen_otp, onew_otp, oaddr_rd, oaddr_wr, owdata, owrite_en, obusy, odone, otimeout
  );

  modport master (
    output istart, inew, iotp_ready, ipad, irdata,
    input  ogen_otp, onew_otp, oaddr_rd, oaddr_wr, owdata, owrite_en, obusy, odone, otimeout
  );
endinterface

// File: rtl/otp_sched.sv
// otp_sched: XORs one receive-RAM block nibble-wise with a stream of OTP pad blocks
// into the transmit RAM. Define OTP_TIMEOUT_EN to bound the wait for each pad block.
module otp_sched #(
  parameter int ADDR_W  = 10,
  parameter int PAD_W   = 64
`ifdef OTP_TIMEOUT_EN
  , parameter int TIMEOUT = 4096
`endif
) (
  input  logic       iclk,
  input  logic       irst_n,
  otp_sched_if.slave bus
);
  localparam int NPAD  = PAD_W / 4;
  localparam int NIB_W = $clog2(NPAD);
  localparam int BLK_W = ADDR_W - NIB_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEW   = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_XOR   = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BLK_W-1:0]  r_blk;
  logic [NIB_W-1:0]  r_nib;
  logic [NIB_W-1:0]  r_wsel;
  logic [PAD_W-1:0]  r_pad;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_wen;
  logic              r_newo;
  logic              r_gen;
  logic              r_busy;
  logic              r_done;
  logic              w_newo;
  logic              w_gen;
  logic              w_busy;
  logic              w_done;
  logic              w_expire;
  logic              w_last_nib;
  logic              w_last_blk;

  assign w_last_nib = (r_nib == NIB_W'(NPAD - 1));
  assign w_last_blk = (r_blk == {BLK_W{1'b1}});

`ifdef OTP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // Ready in the expiry cycle wins, so expiry has to see the live iotp_ready.
  assign w_expire = (r_state == S_WAIT) && !bus.iotp_ready &&
                    (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.istart) begin
          w_state_nxt = bus.inew ? S_NEW : S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_NEW:  w_state_nxt = S_REQ;
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.iotp_ready) begin
          w_state_nxt = S_XOR;
        end else if (w_expire) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_XOR: begin
        if (w_last_nib) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_XOR;
        end
      end
      S_DRAIN: begin
        if (w_last_blk) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pulses are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    w_newo = 1'b0;
    w_gen  = 1'b0;
    w_done = 1'b0;
    w_busy = 1'b1;
    case (w_state_nxt)
      S_IDLE:  w_busy = 1'b0;
      S_NEW:   w_newo = 1'b1;
      S_REQ:   w_gen  = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: w_busy = 1'b1;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_newo <= 1'b0;
      r_gen  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_newo <= w_newo;
      r_gen  <= w_gen;
      r_busy <= w_busy;
      r_done <= w_done;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_blk   <= '0;
      r_nib   <= '0;
      r_wsel  <= '0;
      r_pad   <= '0;
      r_waddr <= '0;
      r_wen   <= 1'b0;
    end else begin
      r_wen   <= (r_state == S_XOR);
      r_waddr <= {r_blk, r_nib};
      r_wsel  <= r_nib;
      if ((r_state == S_WAIT) && bus.iotp_ready) begin
        r_pad <= bus.ipad;
      end
      if (r_state == S_XOR) begin
        r_nib <= r_nib + NIB_W'(1);
      end
      // The block counter only returns to 0 at the end of a block (or an abandoned wait).
      if ((r_state == S_DRAIN) && !w_last_blk) begin
        r_blk <= r_blk + BLK_W'(1);
      end else if ((r_state == S_DONE) || w_expire) begin
        r_blk <= '0;
      end
    end
  end

  assign bus.onew_otp  = r_newo;
  assign bus.ogen_otp  = r_gen;
  assign bus.obusy     = r_busy;
  assign bus.odone     = r_done;
  assign bus.otimeout  = w_expire;
  assign bus.oaddr_rd  = {r_blk, r_nib};
  assign bus.oaddr_wr  = r_waddr;
  assign bus.owrite_en = r_wen;
  assign bus.owdata    = r_wen ? (bus.irdata ^ r_pad[{r_wsel, 2'b00} +: 4]) : 4'h0;
endmodule

// File: tb/tb_otp_sched.sv
// Scoreboard bench for otp_sched: expected RAM writes are queued by the stimulus and
// consumed by a negedge monitor. Works with and without OTP_TIMEOUT_EN.
module tb_otp_sched;
  logic iclk;
  logic irst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wr = 0;
  int   n_gen = 0;
  int   n_new = 0;
  int   n_done = 0;
  int   run_len = 0;

  logic [63:0] resp_pad = 64'h0;
  int          resp_delay = 0;
  bit          resp_en = 1'b0;
  bit          resp_stray = 1'b0;
  int          ram_mode = 0;
  logic [13:0] exp_q[$];

  localparam logic [63:0] P0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] P1 = 64'hFEDCBA9876543210;

  otp_sched_if #(.ADDR_W(10), .PAD_W(64)) bus ();

  otp_sched dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  always @(posedge iclk) cyc <= cyc + 1;

  // Receive RAM model, one-cycle read latency.
  always @(posedge iclk) begin
    logic [9:0] a;
    a = bus.oaddr_rd;
    bus.irdata <= (ram_mode == 0) ? a[3:0] : (a[3:0] ^ a[7:4]);
  end

  task automatic check(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each write and checks run lengths.
  always @(negedge iclk) begin
    logic [13:0] e;
    if (!irst_n) begin
      run_len = 0;
    end else if (bus.owrite_en) begin
      n_wr++;
      run_len++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write addr=%0d data=%h", bus.oaddr_wr, bus.owdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.oaddr_wr, bus.owdata} !== e) begin
          n_bad++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   bus.oaddr_wr, bus.owdata, e[13:4], e[3:0]);
        end
      end
    end else if (run_len != 0) begin
      n_cmp++;
      if (run_len != 16) begin
        n_bad++;
        $display("FAIL write_run got=%0d expected=16", run_len);
      end
      run_len = 0;
    end
    if (bus.ogen_otp) n_gen++;
    if (bus.onew_otp) n_new++;
    if (bus.odone) n_done++;
  end

  // OTP generator model: answers each ogen_otp after resp_delay WAIT cycles.
  initial begin
    bus.iotp_ready = 1'b0;
    bus.ipad = 64'h0;
    forever begin
      @(negedge iclk);
      if (resp_en && bus.ogen_otp) begin
        repeat (resp_delay + 1) @(negedge iclk);
        bus.ipad = resp_pad;
        bus.iotp_ready = 1'b1;
        @(negedge iclk);
        bus.iotp_ready = 1'b0;
        if (resp_stray) begin
          repeat (5) @(negedge iclk);
          bus.ipad = ~resp_pad;
          bus.iotp_ready = 1'b1;
          @(negedge iclk);
          bus.iotp_ready = 1'b0;
          bus.ipad = resp_pad;
        end
      end
    end
  end

  // kind 0: pad P0 with ram=addr[3:0] gives k^(15-k)=F everywhere; kind 1: P1 with mode 1 gives addr[7:4].
  task automatic push_block(input int kind);
    logic [9:0] av;
    for (int a = 0; a < 1024; a++) begin
      av = 10'(a);
      exp_q.push_back({av, (kind == 0) ? 4'hF : av[7:4]});
    end
  endtask

  task automatic pulse_start(input logic nw);
    bus.istart = 1'b1;
    bus.inew = nw;
    @(negedge iclk);
    bus.istart = 1'b0;
    bus.inew = 1'b0;
  endtask

  task automatic run_block(input logic nw, input logic [63:0] pad, input int dly,
                           input bit stray, input int kind, input bit poke);
    int s_gen, s_new, s_done, s_wr, t0, lat;
    bit got;
    resp_pad = pad; resp_delay = dly; resp_stray = stray; ram_mode = kind; resp_en = 1'b1;
    push_block(kind);
    @(negedge iclk);
    #1;
    s_gen = n_gen; s_new = n_new; s_done = n_done; s_wr = n_wr; t0 = cyc;
    pulse_start(nw);
    check("busy_after_start", longint'(bus.obusy), 1);
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      if (bus.ogen_otp) begin
        lat = cyc - t0;
        break;
      end
      @(negedge iclk);
    end
    check("start_to_gen_latency", lat, nw ? 2 : 1);
    if (poke) begin
      repeat (100) @(negedge iclk);
      pulse_start(1'b1);
    end
    got = 1'b0;
    for (int i = 0; i < 64 * (dly + 25) + 200; i++) begin
      @(negedge iclk);
      if (bus.odone) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", longint'(got), 1);
    check("busy_in_done", longint'(bus.obusy), 1);
    @(negedge iclk);
    #1;
    check("busy_after_done", longint'(bus.obusy), 0);
    check("new_pulses", n_new - s_new, nw ? 1 : 0);
    check("gen_pulses", n_gen - s_gen, 64);
    check("done_pulses", n_done - s_done, 1);
    check("write_count", n_wr - s_wr, 1024);
    check("queue_left", exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string nm);
    check(nm, longint'({bus.ogen_otp, bus.onew_otp, bus.oaddr_rd, bus.oaddr_wr, bus.owdata,
                        bus.owrite_en, bus.obusy, bus.odone, bus.otimeout}), 0);
  endtask

  initial begin
    int  s_wr, s_done, t0, tcyc, busy_cnt;
    bit  got, busy_at;
    irst_n = 1'b0;
    bus.istart = 1'b0;
    bus.inew = 1'b0;
    repeat (3) @(negedge iclk);
    check_outputs_zero("reset_outputs");
    irst_n = 1'b1;
    repeat (2) @(negedge iclk);

    run_block(1'b1, P0, 0,  1'b0, 0, 1'b0);
    run_block(1'b0, P0, 1,  1'b1, 0, 1'b0);
    run_block(1'b1, P0, 50, 1'b1, 0, 1'b0);
    run_block(1'b0, P1, 0,  1'b0, 1, 1'b1);

    // Abort in the middle of a pad block.
    resp_pad = P0; resp_delay = 0; resp_stray = 1'b0; ram_mode = 0; resp_en = 1'b1;
    push_block(0);
    @(negedge iclk);
    pulse_start(1'b1);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge iclk);
      if (bus.oaddr_rd == 10'd37) begin
        got = 1'b1;
        break;
      end
    end
    check("reached_addr37", longint'(got), 1);
    #2;
    irst_n = 1'b0;
    #1;
    check_outputs_zero("midblock_reset_outputs");
    exp_q.delete();
    s_wr = n_wr;
    repeat (3) @(negedge iclk);
    irst_n = 1'b1;
    repeat (40) @(negedge iclk);
    #1;
    check("writes_after_reset", n_wr - s_wr, 0);

    run_block(1'b1, P0, 0, 1'b0, 0, 1'b0);

    // Pad generator never answers.
    resp_en = 1'b0;
    @(negedge iclk);
    #1;
    s_done = n_done;
    t0 = cyc;
    pulse_start(1'b0);
`ifdef OTP_TIMEOUT_EN
    got = 1'b0; tcyc = 0; busy_at = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (bus.otimeout) begin
        got = 1'b1;
        tcyc = cyc;
        busy_at = bus.obusy;
        break;
      end
      @(negedge iclk);
    end
    check("timeout_seen", longint'(got), 1);
    check("timeout_cycle", tcyc - t0, 4097);
    check("busy_at_timeout", longint'(busy_at), 1);
    @(negedge iclk);
    check("busy_after_timeout", longint'(bus.obusy), 0);
`else
    busy_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      if (bus.obusy && !bus.otimeout) busy_cnt++;
      @(negedge iclk);
    end
    check("busy_held_no_timeout", busy_cnt, 10000);
    irst_n = 1'b0;
    @(negedge iclk);
    irst_n = 1'b1;
`endif
    @(negedge iclk);
    #1;
    check("no_done_without_pad", n_done - s_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
